// File: rtl/delay_channel_scheduler_if.sv
// Producer/consumer token bus of delay_channel_scheduler: two producer
// channels in, two consumer channels out.
interface delay_channel_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] entry_1;
    logic [DATA_WIDTH-1:0] entry_2;
    logic                  valid_1;
    logic                  valid_2;
    logic                  ready_1;
    logic                  ready_2;
    logic [DATA_WIDTH-1:0] output_1;
    logic [DATA_WIDTH-1:0] output_2;
    logic                  out_valid_1;
    logic                  out_valid_2;

    // Environment side: drives producer tokens, observes grants and emissions.
    modport master (
        output entry_1, entry_2, valid_1, valid_2,
        input  ready_1, ready_2, output_1, output_2, out_valid_1, out_valid_2
    );

    // Scheduler side.
    modport slave (
        input  entry_1, entry_2, valid_1, valid_2,
        output ready_1, ready_2, output_1, output_2, out_valid_1, out_valid_2
    );
endinterface

// File: rtl/delay_channel_scheduler.sv
// Round-robin scheduler sharing one fixed-latency delay pipeline between two
// producer channels. Each accepted token is tagged with its source and
// emitted on the matching consumer output DELAY_NUMBER enabled cycles later.
// A flush request stops acceptance and drains the pipeline, ending with a
// flush_done pulse.
// Optional feature macro: DELAY_SCHED_STATS_EN adds per-channel 16-bit
// grant counters (grant_count_1/grant_count_2), cleared on flush_done.
module delay_channel_scheduler #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DELAY_NUMBER = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic flush,
    delay_channel_scheduler_if.slave bus,
    output logic busy,
    output logic flush_done
`ifdef DELAY_SCHED_STATS_EN
    ,
    output logic [15:0] grant_count_1,
    output logic [15:0] grant_count_2
`endif
);

    localparam int unsigned IDX_W = (DELAY_NUMBER > 1) ? $clog2(DELAY_NUMBER) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DELAY_NUMBER - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic                    last_grant_2;
    logic [DELAY_NUMBER-1:0] stage_valid;
    logic [DELAY_NUMBER-1:0] stage_tag;      // 0 = channel 1, 1 = channel 2
    logic [DATA_WIDTH-1:0]   stage_data [DELAY_NUMBER];

    logic grant_1;
    logic grant_2;
    logic accept_1;
    logic accept_2;
    logic accept;
    logic tail_busy;

    // Arbiter: one grant per cycle, alternating on contention.
    always_comb begin
        grant_1 = 1'b0;
        grant_2 = 1'b0;
        if (enable && (state != ST_DRAIN) && !flush) begin
            if (bus.valid_1 && bus.valid_2) begin
                if (last_grant_2) grant_1 = 1'b1;
                else              grant_2 = 1'b1;
            end else if (bus.valid_1) begin
                grant_1 = 1'b1;
            end else if (bus.valid_2) begin
                grant_2 = 1'b1;
            end
        end
    end

    assign bus.ready_1 = grant_1;
    assign bus.ready_2 = grant_2;
    assign accept_1    = grant_1 & bus.valid_1;
    assign accept_2    = grant_2 & bus.valid_2;
    assign accept      = accept_1 | accept_2;
    assign busy        = |stage_valid;

    // Tokens that will still be in flight after the next shift.
    always_comb begin
        tail_busy = 1'b0;
        for (int unsigned i = 0; i + 1 < DELAY_NUMBER; i++) begin
            tail_busy = tail_busy | stage_valid[IDX_W'(i)];
        end
    end

    // Delay pipeline and registered consumer outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid     <= '0;
            stage_tag       <= '0;
            for (int unsigned i = 0; i < DELAY_NUMBER; i++) begin
                stage_data[IDX_W'(i)] <= '0;
            end
            bus.output_1    <= '0;
            bus.output_2    <= '0;
            bus.out_valid_1 <= 1'b0;
            bus.out_valid_2 <= 1'b0;
        end else if (enable) begin
            stage_valid[0] <= accept;
            stage_tag[0]   <= accept_2;
            stage_data[0]  <= accept_2 ? bus.entry_2 : (accept_1 ? bus.entry_1 : '0);
            for (int unsigned i = 1; i < DELAY_NUMBER; i++) begin
                stage_valid[IDX_W'(i)] <= stage_valid[IDX_W'(i - 1)];
                stage_tag[IDX_W'(i)]   <= stage_tag[IDX_W'(i - 1)];
                stage_data[IDX_W'(i)]  <= stage_data[IDX_W'(i - 1)];
            end
            bus.out_valid_1 <= stage_valid[LAST_IDX] & ~stage_tag[LAST_IDX];
            bus.out_valid_2 <= stage_valid[LAST_IDX] &  stage_tag[LAST_IDX];
            if (stage_valid[LAST_IDX] && !stage_tag[LAST_IDX]) begin
                bus.output_1 <= stage_data[LAST_IDX];
            end
            if (stage_valid[LAST_IDX] && stage_tag[LAST_IDX]) begin
                bus.output_2 <= stage_data[LAST_IDX];
            end
        end else begin
            bus.out_valid_1 <= 1'b0;
            bus.out_valid_2 <= 1'b0;
        end
    end

    // Control FSM, round-robin history and drain completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last_grant_2 <= 1'b1;
            flush_done   <= 1'b0;
        end else if (enable) begin
            flush_done <= 1'b0;
            if (accept) begin
                last_grant_2 <= accept_2;
            end
            case (state)
                ST_IDLE: begin
                    if (flush)       state <= ST_DRAIN;
                    else if (accept) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (flush)                      state <= ST_DRAIN;
                    else if (!accept && !tail_busy) state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (!busy) begin
                        state      <= ST_IDLE;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end else begin
            flush_done <= 1'b0;
        end
    end

`ifdef DELAY_SCHED_STATS_EN
    // Per-channel acceptance counters, wrapping, cleared when a drain completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count_1 <= '0;
            grant_count_2 <= '0;
        end else if (enable) begin
            if ((state == ST_DRAIN) && !busy) begin
                grant_count_1 <= '0;
                grant_count_2 <= '0;
            end else begin
                if (accept_1) grant_count_1 <= grant_count_1 + 16'd1;
                if (accept_2) grant_count_2 <= grant_count_2 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_delay_channel_scheduler.sv
// Self-checking bench for delay_channel_scheduler: directed scenarios plus a
// randomized run, checked every cycle against a timing/arbitration model.
module tb_delay_channel_scheduler;

    localparam int D    = 4;
    localparam int DW   = 16;
    localparam int MAXE = 16384;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic enable = 1'b0;
    logic flush  = 1'b0;
    logic busy;
    logic flush_done;
`ifdef DELAY_SCHED_STATS_EN
    logic [15:0] grant_count_1;
    logic [15:0] grant_count_2;
`endif

    delay_channel_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    delay_channel_scheduler #(.DATA_WIDTH(DW), .DELAY_NUMBER(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .flush      (flush),
        .bus        (bus),
        .busy       (busy),
        .flush_done (flush_done)
`ifdef DELAY_SCHED_STATS_EN
        ,
        .grant_count_1 (grant_count_1),
        .grant_count_2 (grant_count_2)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: acceptances indexed by enabled-edge number.
    bit          acc_v  [MAXE];
    bit          acc_t2 [MAXE];
    logic [15:0] acc_d  [MAXE];
    int          ecount;
    bit          m_drain;
    bit          m_last2;
    logic [15:0] m_out1, m_out2;
    bit          m_ov1, m_ov2, m_fd;
    logic [15:0] m_cnt1, m_cnt2;
    bit          got1, got2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAXE; i++) acc_v[i] = 1'b0;
        ecount  = 0;
        m_drain = 1'b0;
        m_last2 = 1'b1;
        m_out1  = '0;
        m_out2  = '0;
        m_ov1   = 1'b0;
        m_ov2   = 1'b0;
        m_fd    = 1'b0;
        m_cnt1  = '0;
        m_cnt2  = '0;
    endtask

    function automatic bit any_acc(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) begin
            if (j >= 1 && j < MAXE && acc_v[j]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic compare_outputs();
        check("out_valid_1", bus.out_valid_1, m_ov1);
        check("out_valid_2", bus.out_valid_2, m_ov2);
        check("output_1", bus.output_1, m_out1);
        check("output_2", bus.output_2, m_out2);
        check("flush_done", flush_done, m_fd);
        check("busy", busy, any_acc(ecount - D + 1, ecount));
`ifdef DELAY_SCHED_STATS_EN
        check("grant_count_1", grant_count_1, m_cnt1);
        check("grant_count_2", grant_count_2, m_cnt2);
`endif
    endtask

    // One clock: drive at negedge, check grants, advance model at posedge, check outputs.
    task automatic step(input bit en, input bit fl, input bit v1, input bit v2,
                        input logic [15:0] d1, input logic [15:0] d2);
        bit ok, g1, g2, empty;
        int m, j;
        @(negedge clk);
        enable = en; flush = fl;
        bus.valid_1 = v1; bus.valid_2 = v2;
        bus.entry_1 = d1; bus.entry_2 = d2;
        #1;
        ok = en && !m_drain && !fl;
        g1 = ok && v1 && (!v2 || m_last2);
        g2 = ok && v2 && !g1;
        got1 = bus.ready_1;
        got2 = bus.ready_2;
        check("ready_1", got1, g1);
        check("ready_2", got2, g2);
        @(posedge clk);
        if (en) begin
            m     = ecount + 1;
            empty = !any_acc(m - D, m - 1);
            m_fd  = m_drain && empty;
            if (m_drain) begin
                if (empty) m_drain = 1'b0;
            end else if (fl) begin
                m_drain = 1'b1;
            end
            acc_v[m]  = g1 || g2;
            acc_t2[m] = g2;
            acc_d[m]  = g2 ? d2 : d1;
            if (g1 || g2) m_last2 = g2;
            m_ov1 = 1'b0;
            m_ov2 = 1'b0;
            j = m - D;
            if (j >= 1 && acc_v[j]) begin
                if (acc_t2[j]) begin m_ov2 = 1'b1; m_out2 = acc_d[j]; end
                else           begin m_ov1 = 1'b1; m_out1 = acc_d[j]; end
            end
            if (g1) m_cnt1 = m_cnt1 + 16'd1;
            if (g2) m_cnt2 = m_cnt2 + 16'd1;
            if (m_fd) begin m_cnt1 = '0; m_cnt2 = '0; end
            ecount = m;
        end else begin
            m_ov1 = 1'b0;
            m_ov2 = 1'b0;
            m_fd  = 1'b0;
        end
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Reset asserted between clock edges; outputs must clear immediately.
    task automatic async_reset_mid();
        #3;
        rst_n = 1'b0;
        enable = 1'b0; flush = 1'b0;
        bus.valid_1 = 1'b0; bus.valid_2 = 1'b0;
        #1;
        check("rst_out_valid_1", bus.out_valid_1, 1'b0);
        check("rst_out_valid_2", bus.out_valid_2, 1'b0);
        check("rst_output_1", bus.output_1, 16'h0);
        check("rst_output_2", bus.output_2, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, emits;
        bit seen;
        bus.valid_1 = 1'b0; bus.valid_2 = 1'b0;
        bus.entry_1 = '0;   bus.entry_2 = '0;
        model_reset();

        // Power-on reset.
        #1 rst_n = 1'b0;
        #2;
        check("por_out_valid_1", bus.out_valid_1, 1'b0);
        check("por_output_1", bus.output_1, 16'h0);
        check("por_output_2", bus.output_2, 16'h0);
        check("por_busy", busy, 1'b0);
        check("por_flush_done", flush_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single token on channel 1.
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'd1500, 16'h0);
        check("single_grant", {got1, got2}, 2'b10);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            if (k == 3) check("single_early", bus.out_valid_1, 1'b0);
        end
        check("single_ov1", bus.out_valid_1, 1'b1);
        check("single_out1", bus.output_1, 16'd1500);
        check("single_out2", bus.output_2, 16'h0);
        idle(2);

        // Reset with 4 tokens in flight: nothing emitted afterwards.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0300 + 16'(i), 16'h0);
        async_reset_mid();
        emits = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            if (bus.out_valid_1 || bus.out_valid_2) emits++;
        end
        check("post_reset_emits", 32'(emits), 32'd0);

        // Contention: grants alternate starting with channel 1.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(i));
            check("contend_grant", {got1, got2}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i == 4) begin
                check("contend_first_ov1", bus.out_valid_1, 1'b1);
                check("contend_first_out1", bus.output_1, 16'h0100);
            end
            if (i == 5) begin
                check("contend_first_ov2", bus.out_valid_2, 1'b1);
                check("contend_first_out2", bus.output_2, 16'h0201);
            end
        end
        idle(6);

        // Stall: 3 disabled cycles mid-flight delay emission by 3.
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h00AA, 16'h0);
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step(!(k >= 2 && k <= 4), 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            if (bus.out_valid_1) begin seen = 1'b1; n = k; end
        end
        check("stall_latency", 32'(n), 32'd7);
        check("stall_data", bus.output_1, 16'h00AA);

        // Flush with 3 tokens in flight.
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0022);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0033, 16'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0044, 16'h0055);
        check("flush_no_grant", {got1, got2}, 2'b00);
        n = 0;
        emits = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            if (bus.out_valid_1 || bus.out_valid_2) emits++;
            if (flush_done) begin seen = 1'b1; n = k; end
        end
        check("flush_done_delay", 32'(n), 32'd4);
        check("flush_emits", 32'(emits), 32'd3);
        check("flush_busy", busy, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0066);
        check("post_flush_grant", {got1, got2}, 2'b01);
        idle(5);

`ifdef DELAY_SCHED_STATS_EN
        // Grant counters: 5 on channel 1, 3 on channel 2, cleared by drain.
        async_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'(i), 16'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'(i));
        check("stats_cnt1", grant_count_1, 16'd5);
        check("stats_cnt2", grant_count_2, 16'd3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            if (flush_done) seen = 1'b1;
        end
        check("stats_drain_seen", seen, 1'b1);
        check("stats_clr1", grant_count_1, 16'd0);
        check("stats_clr2", grant_count_2, 16'd0);
`endif

        // Randomized traffic with stalls, flushes and mid-run resets.
        for (int c = 0; c < 2000; c++) begin
            step(($urandom % 10) != 0, ($urandom % 40) == 0,
                 ($urandom % 5) < 3, ($urandom % 5) < 3,
                 16'($urandom), 16'($urandom));
            if (c == 700 || c == 1400) async_reset_mid();
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
